row_buffer_tracker: RTL and testbench
=====================================

// Module: row_buffer_tracker
// PURPOSE
//  Per-bank open-row table for the DRAM scheduler, generalised over bank-group/bank/row widths.
//  Classifies each request as HIT/MISS/CONFLICT and holds it pending until the scheduler
//  reports the row opened (row_resolve). Closes all rows on refresh.
//  Closes idle rows after a programmable timeout (close_mask tells the scheduler to issue PRE).
//  Keeps saturating HIT/MISS/CONFLICT performance counters.
// PARAMETERS
//  ROW_BITS      15  row address width
//  BG_BITS       2   bank-group index width
//  BANK_BITS     2   bank-in-group index width; NB = 2**(BG_BITS+BANK_BITS) table entries
//  IDLE_TIMEOUT  64  cycles an open row survives without a hit; 0 disables the timeout
//  CNT_BITS      16  width of each perf counter
// PORTS
//  CLK           in   1         clock, rising edge
//  RST           in   1         asynchronous reset, active-high
//  req_en        in   1         request valid; accepted when req_en && req_ready
//  req_ready     out  1         = !pending && !refresh (combinational)
//  bank_group    in   BG_BITS   request bank group
//  bank          in   BANK_BITS request bank
//  row           in   ROW_BITS  request row
//  row_resolve   in   1         scheduler has opened the pending row (ACT issued)
//  refresh       in   1         all-bank refresh pulse; closes every row
//  stat_valid    out  1         1-cycle pulse: row_stat/row_conflict valid
//  row_stat      out  2         00 IDLE, 01 HIT, 10 MISS, 11 CONFLICT
//  row_conflict  out  ROW_BITS  row currently open in the bank, on CONFLICT; else 0
//  pending       out  1         a MISS/CONFLICT awaits row_resolve
//  close_mask    out  NB        1-cycle pulse per bank closed by timeout (scheduler issues PRE)
//  hit_cnt / miss_cnt / conf_cnt  out  CNT_BITS each  saturating perf counters
// BEHAVIOUR
//  Reset: all table entries invalid; timers 0; pending 0; stat_valid 0; row_stat 00;
//   row_conflict 0; close_mask 0; all counters 0.
//  Index: idx = {bank_group, bank}. Entry = {open, open_row, timer}.
//  Accept (cycle T). Outputs are registered and valid at T+1 with stat_valid=1:
//   - !open[idx]: MISS. Set pending and latch {idx,row}.
//   - open && open_row==row: HIT. Clear timer[idx]; no pending.
//   - open && open_row!=row: CONFLICT. row_conflict=open_row; set pending and latch.
//     The entry stays open (old row) until resolve.
//  When stat_valid=0: row_stat=00 and row_conflict=0.
//  Resolve: row_resolve && pending, with no refresh that cycle:
//   - write open=1, open_row=latched row, timer=0; clear pending at the next edge.
//   - row_resolve while !pending: ignored.
//  Timeout (IDLE_TIMEOUT>0):
//   - every open entry not pending-locked increments timer each cycle.
//   - timer==IDLE_TIMEOUT-1 -> entry closes at the next edge, with close_mask[idx]=1 for that cycle.
//   - several banks may expire together; all their bits are set.
//   - A HIT in the expiring cycle wins: timer resets, no close.
//   - The bank latched by pending never times out.
//  Refresh (highest priority):
//   - clears every open bit and timer and any pending at the next edge.
//   - close_mask is not asserted for refresh.
//   - Same-cycle req_en: not accepted (req_ready=0).
//   - Same-cycle row_resolve: the entry is not written.
//  Counters: each increments by 1 per classified request and saturates at all-ones.
//  Simultaneous resolve and new req_en: req_ready is still 0 that cycle; the new request is
//   accepted from the next cycle.
//  RST mid-operation: immediate return to reset state, including mid-pending.
// TESTING
//  1. After reset, req {bg=1,bk=2,row=0x100} -> T+1 stat=MISS, pending=1.
//     row_resolve -> pending=0. Same req again -> HIT, hit_cnt=1.
//  2. Bank 6 open at 0x100; req row 0x200 -> CONFLICT, row_conflict=0x100.
//     Resolve -> req 0x200 gives HIT.
//  3. IDLE_TIMEOUT=4: open bank 3 and leave it idle -> close_mask=0x0008 exactly 4 cycles
//     after resolve; next req -> MISS.
//  4. Banks 0 and 5 open; refresh while pending on bank 5 -> pending=0, no close_mask;
//     both banks MISS afterwards.
//  5. Same-cycle refresh+req_en -> request dropped. Same-cycle refresh+row_resolve -> entry
//     stays closed.
//  6. CNT_BITS=2: 5 HITs -> hit_cnt=3. Async RST mid-pending -> all outputs 0 immediately.

Source files
------------

// File: rtl/row_buffer_tracker_if.sv
// Scheduler <-> row tracker bundle: request handshake, resolve/refresh
// controls, classification result, timeout close pulses and perf counters.
// master = scheduler side, slave = tracker side.
interface row_buffer_tracker_if #(
    parameter int ROW_BITS  = 15,
    parameter int BG_BITS   = 2,
    parameter int BANK_BITS = 2,
    parameter int CNT_BITS  = 16
);
    localparam int NB = 1 << (BG_BITS + BANK_BITS);

    logic                 req_en;
    logic                 req_ready;
    logic [BG_BITS-1:0]   bank_group;
    logic [BANK_BITS-1:0] bank;
    logic [ROW_BITS-1:0]  row;
    logic                 row_resolve;
    logic                 refresh;
    logic                 stat_valid;
    logic [1:0]           row_stat;
    logic [ROW_BITS-1:0]  row_conflict;
    logic                 pending;
    logic [NB-1:0]        close_mask;
    logic [CNT_BITS-1:0]  hit_cnt;
    logic [CNT_BITS-1:0]  miss_cnt;
    logic [CNT_BITS-1:0]  conf_cnt;

    modport master (
        output req_en, bank_group, bank, row, row_resolve, refresh,
        input  req_ready, stat_valid, row_stat, row_conflict, pending,
        input  close_mask, hit_cnt, miss_cnt, conf_cnt
    );

    modport slave (
        input  req_en, bank_group, bank, row, row_resolve, refresh,
        output req_ready, stat_valid, row_stat, row_conflict, pending,
        output close_mask, hit_cnt, miss_cnt, conf_cnt
    );
endinterface

// File: rtl/row_buffer_tracker.sv
// Per-bank open-row table: classifies requests HIT/MISS/CONFLICT, holds
// MISS/CONFLICT pending until row_resolve, closes rows on refresh or idle
// timeout (close_mask pulse), and keeps saturating perf counters.
// Ports: clk, rst (async, active-high), bus (row_buffer_tracker_if.slave).
module row_buffer_tracker #(
    parameter int ROW_BITS     = 15,
    parameter int BG_BITS      = 2,
    parameter int BANK_BITS    = 2,
    parameter int IDLE_TIMEOUT = 64,
    parameter int CNT_BITS     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    row_buffer_tracker_if.slave  bus
);
    localparam int IB = BG_BITS + BANK_BITS;
    localparam int NB = 1 << IB;
    localparam bit TO_EN = (IDLE_TIMEOUT > 0);
    localparam int TW = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;
    localparam logic [TW-1:0] T_LAST = TO_EN ? TW'(IDLE_TIMEOUT - 1) : '0;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_HIT  = 2'b01;
    localparam logic [1:0] ST_MISS = 2'b10;
    localparam logic [1:0] ST_CONF = 2'b11;

    logic [NB-1:0]       open_q;
    logic [ROW_BITS-1:0] open_row_q [NB];
    logic [TW-1:0]       timer_q [NB];
    logic                pending_q;
    logic [IB-1:0]       p_idx_q;
    logic [ROW_BITS-1:0] p_row_q;
    logic                stat_valid_q;
    logic [1:0]          row_stat_q;
    logic [ROW_BITS-1:0] row_conflict_q;
    logic [NB-1:0]       close_q;
    logic [CNT_BITS-1:0] hit_cnt_q, miss_cnt_q, conf_cnt_q;

    logic [IB-1:0]       idx;
    logic                accept, resolve, hit, miss, conf;
    logic [NB-1:0]       touched, locked, expire;
    logic [1:0]          row_stat_d;
    logic [ROW_BITS-1:0] row_conflict_d;

    assign idx           = {bus.bank_group, bus.bank};
    assign bus.req_ready = !pending_q && !bus.refresh;
    assign accept        = bus.req_en && bus.req_ready;
    assign resolve       = bus.row_resolve && pending_q && !bus.refresh;
    assign hit  = accept && open_q[idx] && (open_row_q[idx] == bus.row);
    assign conf = accept && open_q[idx] && (open_row_q[idx] != bus.row);
    assign miss = accept && !open_q[idx];

    // A bank addressed this cycle or held by the pending request never
    // expires; a conflicting request keeps the old row open until resolve.
    always_comb begin
        touched = '0;
        locked  = '0;
        expire  = '0;
        for (int i = 0; i < NB; i++) begin
            touched[i] = accept && (idx == IB'(i));
            locked[i]  = pending_q && (p_idx_q == IB'(i));
            expire[i]  = TO_EN && open_q[i] && !locked[i] && !touched[i]
                         && (timer_q[i] == T_LAST);
        end
    end

    always_comb begin
        row_stat_d     = ST_IDLE;
        row_conflict_d = '0;
        if (hit) begin
            row_stat_d = ST_HIT;
        end else if (miss) begin
            row_stat_d = ST_MISS;
        end else if (conf) begin
            row_stat_d     = ST_CONF;
            row_conflict_d = open_row_q[idx];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            open_q <= '0;
            for (int i = 0; i < NB; i++) begin
                open_row_q[i] <= '0;
                timer_q[i]    <= '0;
            end
        end else begin
            for (int i = 0; i < NB; i++) begin
                if (bus.refresh) begin
                    open_q[i]  <= 1'b0;
                    timer_q[i] <= '0;
                end else if (resolve && locked[i]) begin
                    open_q[i]     <= 1'b1;
                    open_row_q[i] <= p_row_q;
                    timer_q[i]    <= '0;
                end else if (hit && touched[i]) begin
                    timer_q[i] <= '0;
                end else if (expire[i]) begin
                    open_q[i]  <= 1'b0;
                    timer_q[i] <= '0;
                end else if (TO_EN && open_q[i] && !locked[i] && !touched[i]) begin
                    timer_q[i] <= timer_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= 1'b0;
            p_idx_q   <= '0;
            p_row_q   <= '0;
        end else if (bus.refresh || resolve) begin
            pending_q <= 1'b0;
        end else if (miss || conf) begin
            pending_q <= 1'b1;
            p_idx_q   <= idx;
            p_row_q   <= bus.row;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_valid_q   <= 1'b0;
            row_stat_q     <= ST_IDLE;
            row_conflict_q <= '0;
            close_q        <= '0;
            hit_cnt_q      <= '0;
            miss_cnt_q     <= '0;
            conf_cnt_q     <= '0;
        end else begin
            stat_valid_q   <= accept;
            row_stat_q     <= row_stat_d;
            row_conflict_q <= row_conflict_d;
            close_q        <= bus.refresh ? '0 : expire;
            if (hit && !(&hit_cnt_q))   hit_cnt_q  <= hit_cnt_q + 1'b1;
            if (miss && !(&miss_cnt_q)) miss_cnt_q <= miss_cnt_q + 1'b1;
            if (conf && !(&conf_cnt_q)) conf_cnt_q <= conf_cnt_q + 1'b1;
        end
    end

    assign bus.stat_valid   = stat_valid_q;
    assign bus.row_stat     = row_stat_q;
    assign bus.row_conflict = row_conflict_q;
    assign bus.pending      = pending_q;
    assign bus.close_mask   = close_q;
    assign bus.hit_cnt      = hit_cnt_q;
    assign bus.miss_cnt     = miss_cnt_q;
    assign bus.conf_cnt     = conf_cnt_q;
endmodule

// File: tb/tb_row_buffer_tracker.sv
// Self-checking bench for row_buffer_tracker: directed scenarios followed by
// random traffic, all compared against a behavioural open-row model.
module tb_row_buffer_tracker;
    localparam int RB = 15;
    localparam int BG = 2;
    localparam int BK = 2;
    localparam int TO = 4;
    localparam int CB = 2;
    localparam int NB = 1 << (BG + BK);
    localparam int CMAX = (1 << CB) - 1;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    row_buffer_tracker_if #(
        .ROW_BITS(RB), .BG_BITS(BG), .BANK_BITS(BK), .CNT_BITS(CB)
    ) bus ();

    row_buffer_tracker #(
        .ROW_BITS(RB), .BG_BITS(BG), .BANK_BITS(BK),
        .IDLE_TIMEOUT(TO), .CNT_BITS(CB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural model: which row each bank holds open and how many idle
    // cycles it has seen since it was opened or last hit.
    bit m_open [NB];
    int m_row  [NB];
    int m_age  [NB];
    bit m_pend;
    int m_pidx;
    int m_prow;
    int m_hit, m_miss, m_conf;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < NB; i++) begin
            m_open[i] = 0;
            m_row[i]  = 0;
            m_age[i]  = 0;
        end
        m_pend = 0;
        m_pidx = 0;
        m_prow = 0;
        m_hit  = 0;
        m_miss = 0;
        m_conf = 0;
    endtask

    function automatic int sat(input int v);
        return (v < CMAX) ? v + 1 : CMAX;
    endfunction

    task automatic drive(input bit en, input int bg, input int bk, input int r,
                         input bit rr, input bit rf);
        bus.req_en      = en;
        bus.bank_group  = BG'(bg);
        bus.bank        = BK'(bk);
        bus.row         = RB'(r);
        bus.row_resolve = rr;
        bus.refresh     = rf;
    endtask

    // One clock: predict from the model, clock the DUT, compare everything.
    task automatic step();
        int idx, opidx, oprow, e_rc;
        bit rdy, acc, res, old_pend, is_hit;
        logic [1:0] e_st;
        logic [NB-1:0] e_close;
        #1;
        rdy = !m_pend && !bus.refresh;
        chk("req_ready", bus.req_ready, rdy);
        idx = (int'(bus.bank_group) << BK) + int'(bus.bank);
        acc = bus.req_en && rdy;
        old_pend = m_pend;
        opidx = m_pidx;
        oprow = m_prow;
        e_st = 2'b00;
        e_rc = 0;
        e_close = '0;
        is_hit = 0;
        if (acc) begin
            if (!m_open[idx]) begin
                e_st = 2'b10;
                m_miss = sat(m_miss);
                m_pend = 1;
                m_pidx = idx;
                m_prow = int'(bus.row);
            end else if (m_row[idx] == int'(bus.row)) begin
                e_st = 2'b01;
                is_hit = 1;
                m_hit = sat(m_hit);
            end else begin
                e_st = 2'b11;
                e_rc = m_row[idx];
                m_conf = sat(m_conf);
                m_pend = 1;
                m_pidx = idx;
                m_prow = int'(bus.row);
            end
        end
        if (bus.refresh) begin
            for (int i = 0; i < NB; i++) begin
                m_open[i] = 0;
                m_age[i]  = 0;
            end
            m_pend = 0;
        end else begin
            res = bus.row_resolve && old_pend;
            for (int i = 0; i < NB; i++) begin
                if (res && i == opidx) begin
                    m_open[i] = 1;
                    m_row[i]  = oprow;
                    m_age[i]  = 0;
                end else if (acc && i == idx) begin
                    if (is_hit) m_age[i] = 0;
                end else if (m_open[i] && !(old_pend && i == opidx)) begin
                    m_age[i]++;
                    if (m_age[i] == TO) begin
                        m_open[i]  = 0;
                        m_age[i]   = 0;
                        e_close[i] = 1'b1;
                    end
                end
            end
            if (res) m_pend = 0;
        end
        @(posedge clk);
        #1;
        chk("stat_valid", bus.stat_valid, acc);
        chk("row_stat", bus.row_stat, e_st);
        chk("row_conflict", bus.row_conflict, e_rc);
        chk("pending", bus.pending, m_pend);
        chk("close_mask", bus.close_mask, e_close);
        chk("hit_cnt", bus.hit_cnt, m_hit);
        chk("miss_cnt", bus.miss_cnt, m_miss);
        chk("conf_cnt", bus.conf_cnt, m_conf);
    endtask

    task automatic cyc(input bit en, input int bg, input int bk, input int r,
                       input bit rr, input bit rf);
        drive(en, bg, bk, r, rr, rf);
        step();
        drive(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        m_reset();
        drive(0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stat_valid", bus.stat_valid, 0);
        chk("rst_row_stat", bus.row_stat, 0);
        chk("rst_pending", bus.pending, 0);
        chk("rst_close", bus.close_mask, 0);
        chk("rst_hit_cnt", bus.hit_cnt, 0);
        chk("rst_ready", bus.req_ready, 1);
        rst = 1'b0;

        // 1: miss, resolve, hit on bank 6
        cyc(1, 1, 2, 'h100, 0, 0);
        chk("t1_miss", bus.row_stat, 2'b10);
        chk("t1_pend", bus.pending, 1);
        cyc(0, 0, 0, 0, 1, 0);
        chk("t1_resolved", bus.pending, 0);
        cyc(1, 1, 2, 'h100, 0, 0);
        chk("t1_hit", bus.row_stat, 2'b01);
        chk("t1_hit_cnt", bus.hit_cnt, 1);

        // 2: conflict on bank 6, resolve, hit on new row
        cyc(1, 1, 2, 'h200, 0, 0);
        chk("t2_conf", bus.row_stat, 2'b11);
        chk("t2_conf_row", bus.row_conflict, 'h100);
        cyc(0, 0, 0, 0, 1, 0);
        cyc(1, 1, 2, 'h200, 0, 0);
        chk("t2_hit", bus.row_stat, 2'b01);

        // 3: idle timeout on bank 3
        cyc(0, 0, 0, 0, 0, 1);
        cyc(1, 0, 3, 'h33, 0, 0);
        cyc(0, 0, 0, 0, 1, 0);
        for (int k = 1; k <= TO; k++) begin
            cyc(0, 0, 0, 0, 0, 0);
            chk("t3_close", bus.close_mask, (k == TO) ? 16'h0008 : 16'h0000);
        end
        cyc(1, 0, 3, 'h33, 0, 0);
        chk("t3_remiss", bus.row_stat, 2'b10);
        cyc(0, 0, 0, 0, 1, 0);

        // 4: refresh while conflict pending on bank 5
        cyc(1, 0, 0, 'h10, 0, 0);
        cyc(0, 0, 0, 0, 1, 0);
        cyc(1, 1, 1, 'h50, 0, 0);
        cyc(0, 0, 0, 0, 1, 0);
        cyc(1, 1, 1, 'h51, 0, 0);
        chk("t4_conf", bus.row_stat, 2'b11);
        cyc(0, 0, 0, 0, 0, 1);
        chk("t4_pend", bus.pending, 0);
        chk("t4_close", bus.close_mask, 0);
        cyc(1, 0, 0, 'h10, 0, 0);
        chk("t4_b0_miss", bus.row_stat, 2'b10);
        cyc(0, 0, 0, 0, 1, 0);
        cyc(1, 1, 1, 'h50, 0, 0);
        chk("t4_b5_miss", bus.row_stat, 2'b10);
        cyc(0, 0, 0, 0, 1, 0);

        // 5: refresh blocks request and resolve
        cyc(1, 0, 2, 'h55, 0, 1);
        chk("t5_dropped", bus.stat_valid, 0);
        cyc(1, 0, 2, 'h55, 0, 0);
        cyc(0, 0, 0, 0, 1, 1);
        chk("t5_pend", bus.pending, 0);
        cyc(1, 0, 2, 'h55, 0, 0);
        chk("t5_closed", bus.row_stat, 2'b10);
        cyc(0, 0, 0, 0, 1, 0);

        // 6: saturating hit counter, then async reset mid-pending
        for (int k = 0; k < 5; k++) cyc(1, 0, 2, 'h55, 0, 0);
        chk("t6_hit_sat", bus.hit_cnt, 3);
        cyc(1, 1, 3, 'h77, 0, 0);
        chk("t6_pend", bus.pending, 1);
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_valid", bus.stat_valid, 0);
        chk("t6_rst_stat", bus.row_stat, 0);
        chk("t6_rst_pend", bus.pending, 0);
        chk("t6_rst_hit", bus.hit_cnt, 0);
        chk("t6_rst_miss", bus.miss_cnt, 0);
        m_reset();
        #1 rst = 1'b0;

        // random traffic
        for (int n = 0; n < 1500; n++) begin
            cyc(bit'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                $urandom_range(0, 2) == 0, $urandom_range(0, 40) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
